sync_down_counter: RTL and testbench

- Synchronous, presettable, cascadable binary down counter.
- It is the decrementing counterpart of the team's 161-style up counter. It provides the same load and enable semantics, but counts down and signals a borrow instead of a carry.
- Intended uses:
  - programmable dividers and timeout timers, where a value is preloaded and counted to zero;
  - the low stage of wider down-counter chains, where its borrow feeds the next stage's ENT.

---
 rtl/sync_down_counter.sv | 123 ++++++++++++
 tb/tb_sync_down_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_down_counter.sv
// ---------------------------------------------------------------------------
// sync_down_counter
//
// Synchronous, presettable, cascadable binary down counter. It is the
// decrementing counterpart of the 161-style up counter: the same load and
// enable semantics, but it counts down and flags a borrow instead of a carry.
//
// Typical uses:
//   - programmable dividers / timeout timers (preload, count to zero)
//   - low stage of a wider down-counter chain (RBO feeds next stage's ENT,
//     all stages share ENP)
//
// Parameters:
//   WIDTH   counter width in bits, legal range 2..16 (default 4)
//
// Ports:
//   CLK     in   clock, all state changes on the rising edge except clear
//   CLR_n   in   asynchronous active-low clear of Q, UF and reload register
//   D       in   parallel preset value
//   LOAD_n  in   active-low synchronous load; overrides counting
//   ENP     in   count enable, parallel
//   ENT     in   count enable, trickle; also gates RBO
//   Q       out  registered count value
//   RBO     out  ripple borrow out = ENT & (Q == 0), combinational
//   UF      out  registered underflow pulse, one cycle after a decrement
//                from zero
//
// Build option:
//   SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
//     defined   : a decrement from zero reloads the last value applied via
//                 LOAD_n (divide-by-(D+1) with UF as the tick)
//     undefined : a decrement from zero wraps to all ones and no reload
//                 register exists
// ---------------------------------------------------------------------------
module sync_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             RBO,
    output logic             UF
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             uf_q;
    logic             uf_d;
    logic [WIDTH-1:0] wrap_value;
    logic             at_zero;
    logic             count_en;

    assign at_zero  = (count_q == ZERO);
    assign count_en = ENP & ENT;

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
    // Reload register tracks only explicit loads, so the divide ratio stays
    // fixed while the counter runs.
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    always_comb begin
        reload_d = reload_q;
        if (!LOAD_n) begin
            reload_d = D;
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            reload_q <= ZERO;
        end else begin
            reload_q <= reload_d;
        end
    end

    assign wrap_value = reload_q;
`else
    assign wrap_value = ALL_ONES;
`endif

    // Load beats counting; UF only pulses on the edge that leaves zero by
    // counting, so every other path drives it low.
    always_comb begin
        count_d = count_q;
        uf_d    = 1'b0;
        if (!LOAD_n) begin
            count_d = D;
        end else if (count_en) begin
            if (at_zero) begin
                count_d = wrap_value;
                uf_d    = 1'b1;
            end else begin
                count_d = count_q - ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            count_q <= ZERO;
            uf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            uf_q    <= uf_d;
        end
    end

    assign Q   = count_q;
    assign UF  = uf_q;
    // Independent of ENP and LOAD_n so a chain of stages can share ENP and
    // ripple the borrow through ENT.
    assign RBO = ENT & at_zero;

endmodule

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (WIDTH = 4)
    logic       clr_n, load_n, enp, ent;
    logic [3:0] d, q;
    logic       rbo, uf;

    // Two-stage cascade
    logic       c_clr_n, c_load_n, c_enp, c_ent;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_rbo, lo_uf, hi_rbo, hi_uf;

    sync_down_counter #(.WIDTH(4)) dut (
        .CLK(clk), .CLR_n(clr_n), .D(d), .LOAD_n(load_n),
        .ENP(enp), .ENT(ent), .Q(q), .RBO(rbo), .UF(uf)
    );

    sync_down_counter #(.WIDTH(4)) u_lo (
        .CLK(clk), .CLR_n(c_clr_n), .D(c_d[3:0]), .LOAD_n(c_load_n),
        .ENP(c_enp), .ENT(c_ent), .Q(lo_q), .RBO(lo_rbo), .UF(lo_uf)
    );

    sync_down_counter #(.WIDTH(4)) u_hi (
        .CLK(clk), .CLR_n(c_clr_n), .D(c_d[7:4]), .LOAD_n(c_load_n),
        .ENP(c_enp), .ENT(lo_rbo), .Q(hi_q), .RBO(hi_rbo), .UF(hi_uf)
    );

    typedef struct {
        int         sel;   // 0 = main DUT, 1 = cascade
        logic [7:0] q;
        logic       uf;
        logic       rbo;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   hi_uf_count = 0;
    int   lo_uf_count = 0;

    function automatic void check(string nm, logic [31:0] got, logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, expv);
        end
    endfunction

    // Drive a vector just after the falling edge; expectation is the state
    // after the following rising edge, with these inputs still applied.
    task automatic apply(input logic ld_n, input logic p, input logic t,
                         input logic [3:0] dv, input logic [3:0] eq,
                         input logic euf, input logic erbo, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        load_n = ld_n; enp = p; ent = t; d = dv;
        e.sel = 0; e.q = {4'h0, eq}; e.uf = euf; e.rbo = erbo; e.name = nm;
        sb.push_back(e);
    endtask

    task automatic apply_c(input logic ld_n, input logic p, input logic [7:0] dv,
                           input logic [7:0] eq, input logic euf,
                           input logic erbo, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        c_load_n = ld_n; c_enp = p; c_d = dv;
        e.sel = 1; e.q = eq; e.uf = euf; e.rbo = erbo; e.name = nm;
        sb.push_back(e);
    endtask

    // Monitor: one result per falling edge while expectations are queued
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel == 0) begin
                    check({e.name, "_q"},   {28'h0, q},   {24'h0, e.q});
                    check({e.name, "_uf"},  {31'h0, uf},  {31'h0, e.uf});
                    check({e.name, "_rbo"}, {31'h0, rbo}, {31'h0, e.rbo});
                    $display("txn %-24s q=%0d uf=%0b rbo=%0b", e.name, q, uf, rbo);
                end else begin
                    if (hi_uf) hi_uf_count++;
                    if (lo_uf) lo_uf_count++;
                    check({e.name, "_q"},   {24'h0, hi_q, lo_q}, {24'h0, e.q});
                    check({e.name, "_uf"},  {31'h0, hi_uf},      {31'h0, e.uf});
                    check({e.name, "_rbo"}, {31'h0, hi_rbo},     {31'h0, e.rbo});
                    $display("txn %-24s q=%02h hi_uf=%0b hi_rbo=%0b", e.name, {hi_q, lo_q}, hi_uf, hi_rbo);
                end
            end
        end
    end

    initial begin
        clr_n = 1'b0; load_n = 1'b1; enp = 1'b0; ent = 1'b0; d = 4'h0;
        c_clr_n = 1'b0; c_load_n = 1'b1; c_enp = 1'b0; c_ent = 1'b1; c_d = 8'h00;

        #3;
        check("reset_q",   {28'h0, q},   32'd0);
        check("reset_uf",  {31'h0, uf},  32'd0);
        check("reset_rbo", {31'h0, rbo}, 32'd0);
        ent = 1'b1;
        #1;
        check("reset_rbo_follows_ent", {31'h0, rbo}, 32'd1);
        $display("txn reset q=%0d uf=%0b rbo=%0b", q, uf, rbo);

        @(negedge clk);
        #1;
        clr_n = 1'b1; c_clr_n = 1'b1;

        apply(1'b0, 1'b1, 1'b1, 4'd5, 4'd5, 1'b0, 1'b0, "load_priority");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, "dec_4");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, "dec_3");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, "dec_2");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "dec_1");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "dec_0");
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 1'b1, 1'b0, "reload_from_0");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd4, 1'b0, 1'b0, "after_reload");
`else
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 1'b1, 1'b0, "underflow_wrap");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0, "after_wrap");
`endif
        apply(1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, "load_3");
        apply(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 1'b0, 1'b0, "hold_enp0");
        apply(1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, "hold_ent0");
        apply(1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "load_0_ent0");
        apply(1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, "hold_0_ent0");
        apply(1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "rbo_ignores_enp");
        apply(1'b0, 1'b1, 1'b1, 4'd7, 4'd7, 1'b0, 1'b0, "load_wins_at_zero");
        apply(1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "load_0");
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, "reload_zero_uf");
`else
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 1'b1, 1'b0, "underflow_again");
`endif

        // Clear in the middle of a UF=1 cycle
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("clr_during_uf_q",   {28'h0, q},   32'd0);
        check("clr_during_uf_uf",  {31'h0, uf},  32'd0);
        check("clr_during_uf_rbo", {31'h0, rbo}, 32'd1);
        $display("txn clr_during_uf q=%0d uf=%0b rbo=%0b", q, uf, rbo);
        enp = 1'b0; load_n = 1'b1;
        #1;
        clr_n = 1'b1;

        apply(1'b0, 1'b0, 1'b1, 4'd9, 4'd9, 1'b0, 1'b0, "load_9");

        // Clear mid-cycle with Q = 9, held across an edge with LOAD_n low
        @(negedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("clr_q9_q",   {28'h0, q},   32'd0);
        check("clr_q9_uf",  {31'h0, uf},  32'd0);
        check("clr_q9_rbo", {31'h0, rbo}, 32'd1);
        load_n = 1'b0; d = 4'd5;
        @(posedge clk);
        #1;
        check("clr_dominates_load", {28'h0, q}, 32'd0);
        $display("txn clr_q9 q=%0d uf=%0b rbo=%0b", q, uf, rbo);
        @(negedge clk);
        #1;
        load_n = 1'b1; enp = 1'b0; clr_n = 1'b1;

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, "reload_reg_cleared");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b1, 1'b1, "uf_every_cycle");
        apply(1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, "ar_load_3");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, "ar_2");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "ar_1");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "ar_0");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b1, 1'b0, "ar_reload_3");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd2, 1'b0, 1'b0, "ar_2b");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 1'b0, 1'b0, "ar_1b");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, "ar_0b");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b1, 1'b0, "ar_reload_3b");
`else
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd15, 1'b1, 1'b0, "release_wrap");
        apply(1'b1, 1'b1, 1'b1, 4'd0, 4'd14, 1'b0, 1'b0, "release_dec");

        // Cascade: 0x10 -> 0x0F ... 0x00 -> 0xFF (high UF once) -> 0xFE
        apply_c(1'b0, 1'b1, 8'h10, 8'h10, 1'b0, 1'b0, "casc_load");
        for (int n = 1; n <= 18; n++) begin
            logic [7:0] v;
            v = 8'h10 - 8'(n);
            apply_c(1'b1, 1'b1, 8'h00, v, (n == 17), (v == 8'h00),
                    $sformatf("casc_step%0d", n));
        end
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
`ifndef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
        check("casc_hi_uf_pulses", hi_uf_count, 32'd1);
        check("casc_lo_uf_pulses", lo_uf_count, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
